// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It merges stage stall requests, issues branch
// redirects (or defers them while a fetch is in flight) and keeps saturating performance counters.
module pipeline_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [5:0]        stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] new_pc_o,
    output logic              pending_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  redirect_cnt_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

    logic [5:0]        stall_req;
    logic [5:0]        stall_vec;
    logic              branch_acc;
    logic              redirect;
    logic              fl_if_id;
    logic              fl_id_ex;
    logic [ADDR_W-1:0] new_pc;

    // Deepest requester wins: a stalled stage also holds every stage in front of it.
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem) begin
            stall_req = 6'b011111;
        end else if (stallreq_ex) begin
            stall_req = 6'b001111;
        end else if (stallreq_id) begin
            stall_req = 6'b000111;
        end else if (stallreq_if) begin
            stall_req = 6'b000011;
        end
    end

    assign stall_vec = stall_req | ((state_q == ST_PEND) ? 6'b000011 : 6'b000000);

    // Handshake: branch_i acts as valid, ~stall_vec[3] as ready; an unaccepted branch stays
    // presented by EX until it is accepted. While PEND, EX holds a bubble so branch_i is ignored.
    assign branch_acc = branch_i & ~stall_vec[3];

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        redirect  = 1'b0;
        fl_if_id  = 1'b0;
        fl_id_ex  = 1'b0;
        new_pc    = '0;
        case (state_q)
            ST_RUN: begin
                if (branch_acc) begin
                    fl_id_ex = 1'b1;
                    if (stallreq_if) begin
                        pend_pc_d = branch_target_i;
                        state_d   = ST_PEND;
                    end else begin
                        redirect = 1'b1;
                        fl_if_id = 1'b1;
                        new_pc   = branch_target_i;
                    end
                end
            end
            ST_PEND: begin
                if (!stallreq_if) begin
                    redirect = 1'b1;
                    fl_if_id = 1'b1;
                    new_pc   = pend_pc_q;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if ((stall_vec != 6'b000000) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (redirect && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            pend_pc_q      <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pend_pc_q      <= pend_pc_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held. Where a flush and a stall hit the same
    // pipeline register, the register gives the flush priority and loads a bubble.
    assign stall          = rst ? stall_vec : 6'b000000;
    assign flush_if_id    = rst & fl_if_id;
    assign flush_id_ex    = rst & fl_id_ex;
    assign redirect_o     = rst & redirect;
    assign new_pc_o       = rst ? new_pc : '0;
    assign pending_o      = rst & (state_q == ST_PEND);
    assign stall_cnt_o    = rst ? stall_cnt_q : '0;
    assign redirect_cnt_o = rst ? redirect_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected outputs are queued as each step is driven and
// compared on the following falling edge; a second instance with 4-bit counters checks saturation.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        branch_i;
    logic [31:0] branch_target_i;

    logic [5:0]  stall, s_stall;
    logic        flush_if_id, flush_id_ex, redirect_o, pending_o;
    logic        s_flush_if_id, s_flush_id_ex, s_redirect_o, s_pending_o;
    logic [31:0] new_pc_o, s_new_pc_o;
    logic [31:0] stall_cnt_o, redirect_cnt_o;
    logic [3:0]  s_stall_cnt_o, s_redirect_cnt_o;

    int errors = 0;
    int checks = 0;
    int m_stall = 0;
    int m_red   = 0;

    logic [41:0] exp_q[$];

    pipeline_ctrl #(.ADDR_W(32), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect_o(redirect_o), .new_pc_o(new_pc_o), .pending_o(pending_o),
        .stall_cnt_o(stall_cnt_o), .redirect_cnt_o(redirect_cnt_o)
    );

    pipeline_ctrl #(.ADDR_W(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .stall(s_stall), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .redirect_o(s_redirect_o), .new_pc_o(s_new_pc_o), .pending_o(s_pending_o),
        .stall_cnt_o(s_stall_cnt_o), .redirect_cnt_o(s_redirect_cnt_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // One cycle: drive inputs, queue expected outputs, compare at negedge, advance the counter model.
    // req = {mem, ex, id, if}; e_fl = {flush_if_id, flush_id_ex, redirect_o}
    task automatic step(input string tag, input logic r, input logic [3:0] req, input logic br,
                        input logic [31:0] tgt, input logic [5:0] e_stall, input logic [2:0] e_fl,
                        input logic [31:0] e_pc, input logic e_pend);
        logic [41:0] e;
        rst             = r;
        stallreq_mem    = req[3];
        stallreq_ex     = req[2];
        stallreq_id     = req[1];
        stallreq_if     = req[0];
        branch_i        = br;
        branch_target_i = tgt;
        exp_q.push_back({e_stall, e_fl, e_pc, e_pend});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".out"}, 64'({stall, flush_if_id, flush_id_ex, redirect_o, new_pc_o, pending_o}),
                64'(e));
            chk({tag, ".out4"}, 64'({s_stall, s_flush_if_id, s_flush_id_ex, s_redirect_o, s_new_pc_o,
                s_pending_o}), 64'(e));
        end
        chk({tag, ".scnt"}, 64'(stall_cnt_o), r ? 64'(m_stall) : 64'd0);
        chk({tag, ".rcnt"}, 64'(redirect_cnt_o), r ? 64'(m_red) : 64'd0);
        chk({tag, ".scnt4"}, 64'(s_stall_cnt_o), r ? 64'(sat4(m_stall)) : 64'd0);
        chk({tag, ".rcnt4"}, 64'(s_redirect_cnt_o), r ? 64'(sat4(m_red)) : 64'd0);
        @(posedge clk);
        if (!r) begin
            m_stall = 0;
            m_red   = 0;
        end else begin
            if (e_stall != 6'b000000) m_stall++;
            if (e_fl[0]) m_red++;
        end
        #1;
    endtask

    initial begin
        // reset with every request high
        step("rst0", 1'b0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 6'b000000, 3'b000, 32'h0, 1'b0);
        step("rst1", 1'b0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 6'b000000, 3'b000, 32'h0, 1'b0);
        // stall priority
        step("p_mem_if", 1'b1, 4'b1001, 1'b0, 32'h0, 6'b011111, 3'b000, 32'h0, 1'b0);
        step("p_id",     1'b1, 4'b0010, 1'b0, 32'h0, 6'b000111, 3'b000, 32'h0, 1'b0);
        step("p_ex_id",  1'b1, 4'b0110, 1'b0, 32'h0, 6'b001111, 3'b000, 32'h0, 1'b0);
        step("p_if",     1'b1, 4'b0001, 1'b0, 32'h0, 6'b000011, 3'b000, 32'h0, 1'b0);
        step("p_none",   1'b1, 4'b0000, 1'b0, 32'h0, 6'b000000, 3'b000, 32'h0, 1'b0);
        // direct branch
        step("br_dir",   1'b1, 4'b0000, 1'b1, 32'h0000_1040, 6'b000000, 3'b111, 32'h0000_1040, 1'b0);
        step("post_dir", 1'b1, 4'b0000, 1'b0, 32'h0, 6'b000000, 3'b000, 32'h0, 1'b0);
        // deferred redirect while fetch busy
        step("def_0",    1'b1, 4'b0001, 1'b1, 32'h200, 6'b000011, 3'b010, 32'h0, 1'b0);
        step("def_1",    1'b1, 4'b0001, 1'b0, 32'h0, 6'b000011, 3'b000, 32'h0, 1'b1);
        step("def_2",    1'b1, 4'b0011, 1'b0, 32'h0, 6'b000111, 3'b000, 32'h0, 1'b1);
        step("def_3",    1'b1, 4'b0001, 1'b0, 32'h0, 6'b000011, 3'b000, 32'h0, 1'b1);
        step("def_fall", 1'b1, 4'b0000, 1'b0, 32'h0, 6'b000011, 3'b101, 32'h200, 1'b1);
        step("def_post", 1'b1, 4'b0000, 1'b0, 32'h0, 6'b000000, 3'b000, 32'h0, 1'b0);
        // branch blocked by MEM / EX stall, accepted under ID stall
        step("blk_mem",  1'b1, 4'b1000, 1'b1, 32'h300, 6'b011111, 3'b000, 32'h0, 1'b0);
        step("blk_rel",  1'b1, 4'b0000, 1'b1, 32'h300, 6'b000000, 3'b111, 32'h300, 1'b0);
        step("blk_ex",   1'b1, 4'b0100, 1'b1, 32'h340, 6'b001111, 3'b000, 32'h0, 1'b0);
        step("acc_id",   1'b1, 4'b0010, 1'b1, 32'h400, 6'b000111, 3'b111, 32'h400, 1'b0);
        // reset while a redirect is pending
        step("rp_0",     1'b1, 4'b0001, 1'b1, 32'h500, 6'b000011, 3'b010, 32'h0, 1'b0);
        step("rp_1",     1'b1, 4'b0001, 1'b0, 32'h0, 6'b000011, 3'b000, 32'h0, 1'b1);
        step("rp_rst",   1'b0, 4'b0000, 1'b0, 32'h0, 6'b000000, 3'b000, 32'h0, 1'b0);
        step("rp_run",   1'b1, 4'b0000, 1'b0, 32'h0, 6'b000000, 3'b000, 32'h0, 1'b0);
        // 20 stall cycles: 4-bit counter saturates at 4'hF
        for (int i = 0; i < 20; i++) begin
            step("sat", 1'b1, 4'b1000, 1'b0, 32'h0, 6'b011111, 3'b000, 32'h0, 1'b0);
        end
        step("sat_end",  1'b1, 4'b0000, 1'b0, 32'h0, 6'b000000, 3'b000, 32'h0, 1'b0);
        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
